// File: rtl/id_imm_ctrl.sv
// Decode-side immediate controller: classifies the opcode, drives ImmSrc to the
// external immediate generator and captures ImmExt into a handshaked ID/EX register.
module id_imm_ctrl #(
  parameter logic [31:0] RESET_IMM = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_id,
  input  logic [31:0]      pc_id,
  input  logic             valid_id,
  output logic             ready_id,
  output logic [2:0]       ImmSrc,
  output logic [24:0]      imm_field,
  input  logic [31:0]      ImmExt,
  output logic             valid_ex,
  input  logic             ready_ex,
  output logic [31:0]      imm_ex,
  output logic [31:0]      pc_ex,
  output logic [4:0]       rd_ex,
  output logic             has_imm_ex,
  output logic             illegal_ex,
  input  logic             flush,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  imm_src_e   src_sel;
  logic       has_imm_d;
  logic       illegal_d;
  logic       no_rd;
  logic       accept;
  logic [4:0] rd_d;

  logic             valid_q;
  logic [31:0]      imm_q;
  logic [31:0]      pc_q;
  logic [4:0]       rd_q;
  logic             has_imm_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    src_sel   = IMM_I;
    has_imm_d = 1'b1;
    illegal_d = 1'b0;
    no_rd     = 1'b0;
    unique case (instr_id[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: src_sel = IMM_I;
      7'b0100011: begin src_sel = IMM_S; no_rd = 1'b1; end
      7'b1100011: begin src_sel = IMM_B; no_rd = 1'b1; end
      7'b1101111: src_sel = IMM_J;
      7'b0110111, 7'b0010111: src_sel = IMM_U;
      7'b0110011: has_imm_d = 1'b0;
      default: begin has_imm_d = 1'b0; illegal_d = 1'b1; end
    endcase
  end

  assign ImmSrc    = src_sel;
  assign imm_field = instr_id[31:7];
  assign rd_d      = no_rd ? 5'd0 : instr_id[11:7];
  assign ready_id  = !valid_q || ready_ex;
  assign accept    = valid_id && ready_id && !flush;

  // Flush outranks accept and consume; a consume alone only drops valid and keeps stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      imm_q     <= RESET_IMM;
      pc_q      <= '0;
      rd_q      <= '0;
      has_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      imm_q     <= RESET_IMM;
      pc_q      <= '0;
      rd_q      <= '0;
      has_imm_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      imm_q     <= has_imm_d ? ImmExt : '0;
      pc_q      <= pc_id;
      rd_q      <= rd_d;
      has_imm_q <= has_imm_d;
      illegal_q <= illegal_d;
      if (illegal_d && (cnt_q != '1))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (ready_ex) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_ex    = valid_q;
  assign imm_ex      = imm_q;
  assign pc_ex       = pc_q;
  assign rd_ex       = rd_q;
  assign has_imm_ex  = has_imm_q;
  assign illegal_ex  = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule
